fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the RISC-V core, directly upstream of the boot ROM (byte-addressed, little-endian 32-bit words at 0xBFC00000–0xBFC00FFF). It owns the program counter, drives the ROM address combinationally, and captures the returned word into the IF/ID pipeline register. A valid/ready handshake connects it to decode. It applies redirects from execute and traps misaligned or out-of-window fetches.

## Interface
- ADDR_WIDTH, 32, PC and ROM address width
- DATA_WIDTH, 32, instruction width
- RESET_VECTOR, 32'hBFC00000, PC after reset and ROM base
- ROM_SIZE, 32'h1000, ROM window size in bytes
- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- rom_addr_o  out  ADDR_WIDTH  current PC to ROM
- rom_data_i  in  DATA_WIDTH  instruction word from ROM, combinational from rom_addr_o
- redirect_i  in  1  taken branch/jump from execute
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- valid_o  out  1  IF/ID holds a valid instruction
- ready_i  in  1  decode accepts IF/ID contents this cycle
- instr_o  out  DATA_WIDTH  IF/ID instruction
- pc_o  out  ADDR_WIDTH  PC of instr_o
- pc_plus4_o  out  ADDR_WIDTH  pc_o + 4
- fault_o  out  1  fetch fault pending
- fault_cause_o  out  2  2'b01 misaligned, 2'b10 out of ROM window, 2'b00 none

## Operation
- States: RUN, FAULT.
- Reset values: pc = RESET_VECTOR, state = RUN, valid_o = 0, instr_o = 32'h00000013 (NOP), pc_o = 0, pc_plus4_o = 4, fault_o = 0, fault_cause_o = 0.
- rom_addr_o = pc at all times.
- The IF/ID register loads when load = !valid_o || ready_i. It holds when valid_o && !ready_i.
- Fetchability check on pc:
  - misaligned if pc[1:0] != 0; this has priority.
  - out of window if (pc - RESET_VECTOR) >= ROM_SIZE, using unsigned 32-bit subtraction. Addresses below the base therefore also fault.
- RUN with load and pc fetchable: instr_o <= rom_data_i, pc_o <= pc, pc_plus4_o <= pc + 4, valid_o <= 1, pc <= pc + 4 (mod 2^32).
- RUN with load and pc not fetchable: valid_o <= 0, pc held, fault_o <= 1, fault_cause_o <= cause, state <= FAULT.
- RUN without load: everything held.
- FAULT: no fetch and pc held. valid_o <= valid_o && !ready_i, so a pending older instruction is still delivered. fault_o and fault_cause_o stay held.
- Redirect has highest priority in any state and overrides load:
  - pc <= redirect_pc_i, valid_o <= 0 (held instruction dropped even if ready_i = 0).
  - fault_o <= 0, fault_cause_o <= 0, state <= RUN.
  - If ready_i = 1 in that same cycle, decode still takes the old word. Squashing already-accepted instructions is decode's job.
- The redirect target is checked only when it is next presented as pc. An invalid target faults one cycle later.
- rst_i overrides redirect_i and everything else, including mid-stall and mid-fault.

## Timing
- Zero-latency combinational ROM; fetch-to-IF/ID is 1 cycle.
- First cycle after rst_i falls: rom_addr_o = 0xBFC00000. valid_o = 1 with pc_o = 0xBFC00000 on the next edge.
- Throughput is 1 instruction/cycle while ready_i = 1.
- Redirect asserted in cycle n: valid_o = 0 in n+1; target instruction valid in n+2 (1-bubble penalty).
- Stall: instr_o, pc_o and valid_o are stable for every cycle ready_i = 0. pc does not advance.
- Wrap-around: after 0xBFC00FFC the next pc is 0xBFC01000, which faults with cause 2'b10 on its load cycle.

## Structure
- Package fetch_pkg holds:
  - RESET_VECTOR, ROM_SIZE, NOP_INSTR = 32'h00000013
  - fault cause enum: FC_NONE, FC_MISALIGN, FC_RANGE
  - state enum: FS_RUN, FS_FAULT
- One sub-module is natural: pc_gen (next-PC mux, PC register, fetchability check). fetch_stage wraps it with the IF/ID register and the FSM.

## Test plan
- Reset, then 4 cycles with ready_i = 1 and ROM words 0x11111111..0x44444444 → valid_o = 1; pc_o = 0xBFC00000, 04, 08, 0C; instr_o matches in order.
- ready_i = 0 for 3 cycles after the first instruction → instr_o, pc_o and valid_o frozen and rom_addr_o stays 0xBFC00004. On release, pc_o = 0xBFC00004 next.
- redirect_i with redirect_pc_i = 0xBFC00100 while valid_o = 1 and ready_i = 0 → next cycle valid_o = 0; following cycle pc_o = 0xBFC00100.
- Redirect to 0xBFC00102 → one cycle later fault_o = 1, fault_cause_o = 2'b01, valid_o = 0. A redirect to 0xBFC00000 clears the fault and fetch resumes.
- Sequential run to 0xBFC00FFC → that word is delivered. Next load cycle gives fault_o = 1, cause 2'b10, pc = 0xBFC01000. Redirect to 0xBFBFFFFC also gives cause 2'b10.
- rst_i asserted mid-stall with valid_o = 1 and fault pending → next cycle all outputs at reset values and pc = 0xBFC00000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and enums for the instruction fetch stage.
package fetch_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] ROM_SIZE     = 32'h00001000;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_e;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Program counter register, next-PC selection and fetchability check of the current PC.
module pc_gen
  import fetch_pkg::*;
#(
  parameter int                  AW       = 32,
  parameter logic [AW-1:0]       RST_VEC  = fetch_pkg::RESET_VECTOR,
  parameter logic [AW-1:0]       WIN_SIZE = fetch_pkg::ROM_SIZE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  input  logic          i_advance,
  output logic [AW-1:0] o_pc,
  output fault_cause_e  o_cause
);
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_offset;

  always_ff @(posedge clk_i) begin
    if (rst_i)          r_pc <= RST_VEC;
    else if (i_redirect) r_pc <= i_redirect_pc;
    else if (i_advance)  r_pc <= r_pc + AW'(4);
  end

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign w_offset = r_pc - RST_VEC;

  always_comb begin
    o_cause = FC_NONE;
    if (r_pc[1:0] != 2'b00)       o_cause = FC_MISALIGN;
    else if (w_offset >= WIN_SIZE) o_cause = FC_RANGE;
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generator, IF/ID register with valid/ready handshake, fault FSM.
module fetch_stage #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter logic [ADDR_WIDTH-1:0] ROM_SIZE     = fetch_pkg::ROM_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o,
  output logic [1:0]            fault_cause_o
);
  import fetch_pkg::*;

  fetch_state_e          r_state, w_state_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_fault, w_fault_nxt;
  fault_cause_e          r_cause, w_cause_nxt;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc_q, r_pc4_q;
  logic [ADDR_WIDTH-1:0] w_pc;
  fault_cause_e          w_pc_cause;
  logic                  w_load, w_capture, w_advance;

  pc_gen #(
    .AW       (ADDR_WIDTH),
    .RST_VEC  (RESET_VECTOR),
    .WIN_SIZE (ROM_SIZE)
  ) u_pc_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .i_advance     (w_advance),
    .o_pc          (w_pc),
    .o_cause       (w_pc_cause)
  );

  assign w_load = !r_valid || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= FS_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_cause_nxt = r_cause;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    // Redirect drops any held word, even one decode is stalling on.
    if (redirect_i) begin
      w_state_nxt = FS_RUN;
      w_valid_nxt = 1'b0;
      w_fault_nxt = 1'b0;
      w_cause_nxt = FC_NONE;
    end else begin
      case (r_state)
        FS_RUN: begin
          if (w_load) begin
            if (w_pc_cause == FC_NONE) begin
              w_capture   = 1'b1;
              w_advance   = 1'b1;
              w_valid_nxt = 1'b1;
            end else begin
              w_valid_nxt = 1'b0;
              w_fault_nxt = 1'b1;
              w_cause_nxt = w_pc_cause;
              w_state_nxt = FS_FAULT;
            end
          end
        end
        FS_FAULT: w_valid_nxt = r_valid && !ready_i;
        default:  w_state_nxt = FS_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= FC_NONE;
      r_instr <= DATA_WIDTH'(NOP_INSTR);
      r_pc_q  <= '0;
      r_pc4_q <= ADDR_WIDTH'(4);
    end else begin
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
      r_cause <= w_cause_nxt;
      if (w_capture) begin
        r_instr <= rom_data_i;
        r_pc_q  <= w_pc;
        r_pc4_q <= w_pc + ADDR_WIDTH'(4);
      end
    end
  end

  assign rom_addr_o    = w_pc;
  assign valid_o       = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_q;
  assign pc_plus4_o    = r_pc4_q;
  assign fault_o       = r_fault;
  assign fault_cause_o = r_cause;
endmodule
